// File: rtl/iir_out_fifo.sv
// Output FIFO behind the iir filter: absorbs bursts from a source without backpressure,
// presents first-word fall-through samples to a stalling consumer and flags lost samples.
module iir_out_fifo #(
   parameter int NB    = 10,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          VIN,
   input  logic [NB-1:0] DIN,
   input  logic          RDY,
   output logic          VOUT,
   output logic [NB-1:0] DOUT,
   output logic [AW:0]   COUNT,
   output logic          FULL,
   output logic          EMPTY,
   output logic          OVF,
   input  logic          OVF_CLR
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [NB-1:0] mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [AW:0]   cnt;
   logic          pop;
   logic          push;
   logic          drop;

   // Status flags come purely from the registered count, never from pointer equality.
   assign FULL  = (cnt == DEPTH_C);
   assign EMPTY = (cnt == '0);
   assign COUNT = cnt;
   assign VOUT  = ~EMPTY;
   assign DOUT  = mem[rp];

   // A full FIFO still accepts a sample when the head leaves in the same cycle.
   assign pop  = VOUT & RDY;
   assign push = VIN & (~FULL | pop);
   assign drop = VIN & FULL & ~pop;

   always_ff @(posedge CLK) begin
      if (push && !RST) begin
         mem[wp] <= DIN;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) begin
            wp <= wp + AW'(1);
         end
         if (pop) begin
            rp <= rp + AW'(1);
         end
         if (push && !pop) begin
            cnt <= cnt + (AW+1)'(1);
         end else if (pop && !push) begin
            cnt <= cnt - (AW+1)'(1);
         end
      end
   end

   // A drop in the same cycle as a clear request keeps the flag set.
   always_ff @(posedge CLK) begin
      if (RST) begin
         OVF <= 1'b0;
      end else if (drop) begin
         OVF <= 1'b1;
      end else if (OVF_CLR) begin
         OVF <= 1'b0;
      end
   end

endmodule

// File: tb/tb_iir_out_fifo.sv
// Directed bench for iir_out_fifo: hand-computed vectors checked with immediate assertions.
module tb_iir_out_fifo;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       VIN = 1'b0;
   logic [9:0] DIN = '0;
   logic       RDY = 1'b0;
   logic       OVF_CLR = 1'b0;
   logic       VOUT;
   logic [9:0] DOUT;
   logic [3:0] COUNT;
   logic       FULL;
   logic       EMPTY;
   logic       OVF;

   int checks = 0;
   int errors = 0;

   iir_out_fifo #(.NB(10), .DEPTH(8), .AW(3)) dut (
      .CLK(CLK), .RST(RST), .VIN(VIN), .DIN(DIN), .RDY(RDY),
      .VOUT(VOUT), .DOUT(DOUT), .COUNT(COUNT), .FULL(FULL),
      .EMPTY(EMPTY), .OVF(OVF), .OVF_CLR(OVF_CLR)
   );

   always #5 CLK = ~CLK;

   // Advance one rising edge and settle just after it, away from the edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   initial begin
      // Reset
      RST = 1'b1;
      step();
      RST = 1'b0;
      check("rst_count", 32'(COUNT), 0);
      check("rst_empty", 32'(EMPTY), 1);
      check("rst_full",  32'(FULL), 0);
      check("rst_vout",  32'(VOUT), 0);
      check("rst_ovf",   32'(OVF), 0);

      // Three pushes with the consumer stalled, then drain
      VIN = 1'b1;
      DIN = 10'd5;   step();
      DIN = 10'(-3); step();
      DIN = 10'd511; step();
      VIN = 1'b0;
      check("burst_count", 32'(COUNT), 3);
      check("burst_vout",  32'(VOUT), 1);
      RDY = 1'b1;
      check("drain_0", 32'(DOUT), 5);       step();
      check("drain_1", 32'(DOUT), 32'h3FD); step();
      check("drain_2", 32'(DOUT), 511);     step();
      RDY = 1'b0;
      check("drain_empty", 32'(EMPTY), 1);
      check("drain_ovf",   32'(OVF), 0);

      // Streaming: one in, one out per cycle across two pointer wraps
      RDY = 1'b1;
      VIN = 1'b1;
      for (int i = 0; i < 20; i++) begin
         DIN = 10'(i);
         step();
         check("stream_dout",  32'(DOUT), 32'(i));
         check("stream_count", 32'(COUNT), 1);
      end
      VIN = 1'b0;
      step();
      RDY = 1'b0;
      check("stream_empty", 32'(EMPTY), 1);

      // Overflow: ten pushes into eight slots
      VIN = 1'b1;
      for (int i = 0; i < 10; i++) begin
         DIN = 10'(100 + i);
         step();
         if (i == 7) begin
            check("ovf_full", 32'(FULL), 1);
            check("ovf_not_yet", 32'(OVF), 0);
         end
         if (i == 8) check("ovf_set", 32'(OVF), 1);
      end
      VIN = 1'b0;
      check("ovf_count", 32'(COUNT), 8);
      RDY = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("ovf_drain", 32'(DOUT), 32'(100 + i));
         step();
      end
      RDY = 1'b0;
      check("ovf_drain_empty", 32'(EMPTY), 1);
      check("ovf_sticky", 32'(OVF), 1);
      OVF_CLR = 1'b1;
      step();
      OVF_CLR = 1'b0;
      check("ovf_clr", 32'(OVF), 0);

      // Full with simultaneous push and pop
      VIN = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         DIN = 10'(i);
         step();
      end
      check("fpp_full", 32'(FULL), 1);
      DIN = 10'd9;
      RDY = 1'b1;
      check("fpp_head", 32'(DOUT), 1);
      step();
      VIN = 1'b0;
      check("fpp_count", 32'(COUNT), 8);
      check("fpp_ovf",   32'(OVF), 0);
      for (int i = 2; i <= 9; i++) begin
         check("fpp_drain", 32'(DOUT), 32'(i));
         step();
      end
      RDY = 1'b0;
      check("fpp_empty", 32'(EMPTY), 1);

      // Reset mid-operation with a sample offered in the same cycle
      VIN = 1'b1;
      for (int i = 0; i < 5; i++) begin
         DIN = 10'(10 + i);
         step();
      end
      check("mid_count5", 32'(COUNT), 5);
      RST = 1'b1;
      DIN = 10'd77;
      step();
      RST = 1'b0;
      VIN = 1'b0;
      check("mid_count", 32'(COUNT), 0);
      check("mid_empty", 32'(EMPTY), 1);
      check("mid_vout",  32'(VOUT), 0);
      VIN = 1'b1;
      DIN = 10'd42;
      step();
      VIN = 1'b0;
      check("mid_first", 32'(DOUT), 42);
      check("mid_count1", 32'(COUNT), 1);
      RDY = 1'b1;
      step();
      RDY = 1'b0;
      check("mid_empty2", 32'(EMPTY), 1);

      // Drop and clear in the same cycle: set wins
      VIN = 1'b1;
      for (int i = 0; i < 8; i++) begin
         DIN = 10'(200 + i);
         step();
      end
      check("sc_full", 32'(FULL), 1);
      check("sc_ovf0", 32'(OVF), 0);
      OVF_CLR = 1'b1;
      step();
      VIN = 1'b0;
      check("sc_set_wins", 32'(OVF), 1);
      check("sc_count", 32'(COUNT), 8);
      step();
      OVF_CLR = 1'b0;
      check("sc_clr", 32'(OVF), 0);
      check("sc_head", 32'(DOUT), 200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/iir_out_fifo.md
# iir_out_fifo

Output buffer placed directly downstream of the `iir` filter. It captures every valid filter output (`VIN`/`DIN`, driven by the filter's `VOUT`/`Y`) into a small circular FIFO. It presents the samples to a consumer that may stall, using a valid/ready handshake. The filter has no backpressure, so the block absorbs bursts, reports occupancy, and flags any lost sample with a sticky overflow bit.

## Interface
- `NB`, 10, sample width in bits (matches the filter output width)
- `DEPTH`, 8, number of FIFO entries; must be a power of 2, minimum 2
- `AW`, 3, pointer width, equal to log2(`DEPTH`)
- `CLK` input 1: single clock; all state updates on its rising edge
- `RST` input 1: reset, synchronous and active-high
- `VIN` input 1: input sample valid, from filter `VOUT`
- `DIN` input `NB`: input sample, two's complement, from filter `Y`
- `RDY` input 1: consumer ready
- `VOUT` output 1: head sample valid
- `DOUT` output `NB`: head sample
- `COUNT` output `AW+1`: current occupancy, range 0..`DEPTH`
- `FULL` output 1: `COUNT == DEPTH`
- `EMPTY` output 1: `COUNT == 0`
- `OVF` output 1: sticky overflow flag
- `OVF_CLR` input 1: clears `OVF`

## Operation
- Storage is a register array `mem[0..DEPTH-1]` of `NB` bits, with write pointer `wp`, read pointer `rp` (each `AW` bits, wrapping modulo `DEPTH`) and a counter `cnt`.
- Pop: `pop = VOUT & RDY`. A pop advances `rp`.
- Push: `push = VIN & (~FULL | pop)`. A push writes `DIN` to `mem[wp]` and advances `wp`.
- Counter update:
  - push without pop: `cnt + 1`
  - pop without push: `cnt - 1`
  - both or neither: unchanged
- Drop: `VIN & FULL & ~pop`. The sample is discarded; `wp`, `cnt` and `mem` are unchanged, and `OVF` is set to 1 on the next edge.
- `OVF` clearing:
  - `OVF` stays set until `RST` or `OVF_CLR`.
  - If a drop and `OVF_CLR` occur in the same cycle, set wins (`OVF` = 1).
- Output decode:
  - `VOUT = ~EMPTY`
  - `DOUT = mem[rp]` (first-word fall-through, combinational read of registered storage)
  - When `EMPTY`, `DOUT` is don't-care and the bench must not check it.
- Data is passed unmodified, with no arithmetic, sign change or truncation. Order is strictly FIFO.
- `RDY` while `EMPTY` has no effect. `pop` is gated by `VOUT`.

## Timing
- On reset, the following take effect on the first rising edge with `RST`=1:
  - `wp`=0, `rp`=0, `cnt`=0
  - `COUNT`=0, `EMPTY`=1, `FULL`=0, `VOUT`=0, `OVF`=0
  - `mem` is not cleared.
- `RST` asserted mid-operation discards all stored samples at that edge. A `VIN` sample present in the same cycle as `RST` is not stored.
- Latency: a sample pushed into an empty FIFO at edge n appears on `VOUT`/`DOUT` immediately after edge n, so it can be popped at edge n+1. The minimum DIN-to-DOUT latency is 1 cycle.
- Throughput is one push and one pop per cycle, sustained indefinitely when `RDY`=1.
- Full with simultaneous push and pop: both occur, the count stays at `DEPTH`, there is no drop and `OVF` is unchanged.
- Empty with `VIN`=1: push only. There is no bypass to `DOUT` within the same cycle.
- Pointer wrap-around: on reaching `DEPTH-1`, a pointer returns to 0 on its next advance. `FULL` and `EMPTY` are derived from `cnt`, not from pointer equality.
- `FULL`, `EMPTY` and `COUNT` are decoded from registered `cnt` and carry no combinational path from inputs. `VOUT` and `DOUT` depend only on registered state.

## Test plan
- Reset, then `VIN`=1 for 3 cycles with `DIN` = 5, -3, 511 and `RDY`=0.
  - Required: `COUNT`=3 and `VOUT`=1.
  - Then `RDY`=1: `DOUT` = 5, -3, 511 on consecutive cycles, then `EMPTY`=1 and `OVF`=0.
- Streaming: `VIN`=1 and `RDY`=1 continuously for 20 cycles with `DIN` = 0..19.
  - Required: `DOUT` reproduces 0..19 in order, one cycle behind, with `COUNT` ≤ 1 throughout. This exercises pointer wrap twice.
- Overflow: `RDY`=0, push 10 samples 100..109.
  - Required: `FULL`=1 after the 8th push, `OVF`=1 after the 9th.
  - Draining yields exactly 100..107. Then `OVF_CLR` pulse: `OVF`=0.
- Full with simultaneous push and pop: fill 8 entries (1..8), then one cycle with `VIN`=1, `DIN`=9, `RDY`=1.
  - Required: `DOUT` was 1, `COUNT` stays 8, `OVF`=0, and the drain order is 2..9.
- Reset mid-operation: with 5 entries stored, assert `RST` for one cycle while `VIN`=1.
  - Required: `COUNT`=0, `EMPTY`=1 and `VOUT`=0 after the edge. The next pushed sample (42) is the first one read out.
- Overflow set versus clear: with the FIFO full and `RDY`=0, drive `VIN`=1 and `OVF_CLR`=1 in the same cycle.
  - Required: `OVF`=1 afterwards. A later `OVF_CLR` alone gives `OVF`=0.
